dds_rate_divider: RTL

Parametrised programmable clock-enable generator for the DDS datapath. It divides the system clock by a runtime-selected ratio chosen from two divisor inputs. It produces either a one-cycle tick or a 50%-duty square output. Ratio changes are applied glitch-free at the next terminal count, and a pending flag is exposed to the controller.

---
 rtl/dds_rate_divider_if.sv | 27 ++
 rtl/dds_rate_divider.sv | 76 +++++++
 2 files changed

// File: rtl/dds_rate_divider_if.sv
// Control and status bundle of the DDS rate divider: divisor selection,
// enables and the tick / square / status outputs.
interface dds_rate_divider_if #(
    parameter int WIDTH = 9
) ();
    logic             init;
    logic             en;
    logic             select;
    logic [WIDTH-1:0] div_a;
    logic [WIDTH-1:0] div_b;
    logic             mode;
    logic             tick;
    logic             dds_clk;
    logic             pending;
    logic [WIDTH-1:0] cur_div;
    logic [WIDTH-1:0] count;

    modport master (
        output init, en, select, div_a, div_b, mode,
        input  tick, dds_clk, pending, cur_div, count
    );

    modport slave (
        input  init, en, select, div_a, div_b, mode,
        output tick, dds_clk, pending, cur_div, count
    );
endinterface

// File: rtl/dds_rate_divider.sv
// Programmable clock-enable generator: divides clk by N(cur_div), producing a
// one-cycle tick or a 50% square, with ratio changes taken at terminal count.
module dds_rate_divider #(
    parameter int WIDTH = 9
) (
    input  logic                clk,
    input  logic                reset,
    dds_rate_divider_if.slave   bus
);
    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] cur_div_r;
    logic             tick_r;
    logic             sq_r;
    logic [WIDTH-1:0] sel_div_s;
    logic [WIDTH-1:0] reload_s;

    // A zero divisor behaves as divide-by-one
    function automatic logic [WIDTH-1:0] eff_div(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] r;
        if (x == ZERO_W) begin
            r = ONE_W;
        end else begin
            r = x;
        end
        return r;
    endfunction

    // Selected divisor and the reload value it implies
    always_comb begin
        sel_div_s = ZERO_W;
        reload_s  = ZERO_W;
        if (bus.select) begin
            sel_div_s = bus.div_b;
        end else begin
            sel_div_s = bus.div_a;
        end
        reload_s = eff_div(sel_div_s) - ONE_W;
    end

    // Down-counter, ratio load at terminal count, tick pulse and square toggle
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r   <= ZERO_W;
            cur_div_r <= ZERO_W;
            tick_r    <= 1'b0;
            sq_r      <= 1'b0;
        end else if (bus.init) begin
            cur_div_r <= sel_div_s;
            count_r   <= reload_s;
            tick_r    <= 1'b0;
            sq_r      <= 1'b0;
        end else if (bus.en) begin
            if (count_r == ZERO_W) begin
                tick_r    <= 1'b1;
                sq_r      <= ~sq_r;
                cur_div_r <= sel_div_s;
                count_r   <= reload_s;
            end else begin
                count_r   <= count_r - ONE_W;
                tick_r    <= 1'b0;
            end
        end else begin
            tick_r <= 1'b0;
        end
    end

    // sq toggles in both modes, so switching mode needs no resynchronisation
    assign bus.tick    = tick_r;
    assign bus.dds_clk = bus.mode ? sq_r : tick_r;
    assign bus.pending = (sel_div_s != cur_div_r);
    assign bus.cur_div = cur_div_r;
    assign bus.count   = count_r;
endmodule
